// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - single-port data memory arbiter between CPU load/store path and DMA requester
module data_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_lock,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
);

    typedef enum logic {FREE, LOCKED} arbState;

    localparam logic [3:0] starveLimit = 4'(STARVE_LIMIT);
    localparam logic [3:0] lockMax     = 4'(LOCK_MAX);

    arbState    state, nextState;
    logic [3:0] waitCnt, nextWait;
    logic [3:0] lockCnt, nextLock;
    logic       cpuGrant, dmaGrant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FREE;
            waitCnt <= 4'd0;
            lockCnt <= 4'd0;
            owner   <= 2'b00;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
            lockCnt <= nextLock;
            if (cpuGrant)
                owner <= 2'b01;
            else if (dmaGrant)
                owner <= 2'b10;
        end
    end

    // Grants are masked by reset so a burst is cut off the moment reset rises.
    always_comb begin
        cpuGrant = 1'b0;
        dmaGrant = 1'b0;
        if (!reset) begin
            if (state == LOCKED) begin
                dmaGrant = dma_req;
            end else if (cpu_req && dma_req) begin
                if (waitCnt == starveLimit)
                    dmaGrant = 1'b1;
                else
                    cpuGrant = 1'b1;
            end else begin
                cpuGrant = cpu_req;
                dmaGrant = dma_req;
            end
        end
    end

    // lockCnt counts burst beats already granted, including the one that opened the lock.
    always_comb begin
        nextState = state;
        nextLock  = lockCnt;
        nextWait  = 4'd0;
        if (dma_req && !dmaGrant)
            nextWait = (waitCnt == starveLimit) ? waitCnt : waitCnt + 4'd1;
        case (state)
            FREE: begin
                if (dmaGrant && dma_lock && lockMax > 4'd1) begin
                    nextState = LOCKED;
                    nextLock  = 4'd1;
                end
            end
            LOCKED: begin
                if (!dma_req || !dma_lock || (lockCnt + 4'd1) >= lockMax) begin
                    nextState = FREE;
                    nextLock  = 4'd0;
                    nextWait  = 4'd0;
                end else begin
                    nextLock = lockCnt + 4'd1;
                end
            end
            default: begin
                nextState = FREE;
                nextLock  = 4'd0;
            end
        endcase
    end

    always_comb begin
        cpu_ack   = cpuGrant;
        dma_ack   = dmaGrant;
        cpu_stall = cpu_req & ~cpuGrant;
        cpu_rdata = mem_rdata;
        dma_rdata = mem_rdata;
        mem_we    = (cpuGrant & cpu_we) | (dmaGrant & dma_we);
        mem_re    = (cpuGrant & ~cpu_we) | (dmaGrant & ~dma_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpuGrant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dmaGrant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_lock = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, dma_ack, mem_we, mem_re;
    logic [1:0]  owner;

    logic [31:0] tbMem [0:255];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [36:0] vec;
        bit          chk;
        bit          fromDma;
        logic [31:0] data;
    } expT;
    expT sbq[$];
    expT e;

    data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tbMem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) tbMem[mem_addr[7:0]] <= mem_wdata;

    wire [36:0] obs = {cpu_ack, dma_ack, cpu_stall, mem_we, mem_re, mem_addr};

    function automatic expT mk(bit c, bit d, bit s, bit we, bit re, logic [31:0] a,
                               bit chk, bit fromDma, logic [31:0] data);
        expT r;
        r.vec = {c, d, s, we, re, a};
        r.chk = chk;
        r.fromDma = fromDma;
        r.data = data;
        return r;
    endfunction

    task automatic setCpu(bit req, bit we, logic [31:0] a, logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic setDma(bit req, bit we, bit lock, logic [31:0] a, logic [31:0] d);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = a; dma_wdata = d;
    endtask

    task automatic test_reset();
        setCpu(1, 0, 32'h10, 0);
        @(negedge clk);
        total++;
        if (obs !== {3'b001, 2'b00, 32'h0}) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", obs, {3'b001, 2'b00, 32'h0});
        end
        total++;
        if (owner !== 2'b00) begin bad++; $display("FAIL reset_owner got=%b want=00", owner); end
        @(posedge clk); #1;
        reset = 0;
        setCpu(0, 0, 0, 0);
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                setCpu(1, 1, 32'h10, 32'hDEADBEEF);
                sbq.push_back(mk(1, 0, 0, 1, 0, 32'h10, 0, 0, 0));
            end else begin
                setCpu(1, 0, 32'h10, 0);
                sbq.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 0, 32'hDEADBEEF));
            end
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs !== e.vec) begin bad++; $display("FAIL write_read cyc%0d got=%h want=%h", i, obs, e.vec); end
            if (e.chk) begin
                rd = e.fromDma ? dma_rdata : cpu_rdata;
                total++;
                if (rd !== e.data) begin bad++; $display("FAIL write_read_data got=%h want=%h", rd, e.data); end
            end
            @(posedge clk); #1;
            total++;
            if (owner !== 2'b01) begin bad++; $display("FAIL write_read_owner cyc%0d got=%b want=01", i, owner); end
        end
        setCpu(0, 0, 0, 0);
    endtask

    task automatic test_starvation();
        logic [31:0] rd;
        setCpu(1, 0, 32'h10, 0);
        setDma(1, 0, 0, 32'h14, 0);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                sbq.push_back(mk(0, 1, 1, 0, 1, 32'h14, 1, 1, 32'h0BADF00D));
            else
                sbq.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 0, 32'hDEADBEEF));
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs !== e.vec) begin bad++; $display("FAIL starvation cyc%0d got=%h want=%h", i, obs, e.vec); end
            rd = e.fromDma ? dma_rdata : cpu_rdata;
            total++;
            if (rd !== e.data) begin bad++; $display("FAIL starvation_data cyc%0d got=%h want=%h", i, rd, e.data); end
            @(posedge clk); #1;
        end
        setCpu(0, 0, 0, 0);
        setDma(0, 0, 0, 0, 0);
    endtask

    task automatic test_lock_burst();
        int beat = 0;
        int stalls = 0;
        bit dmaTurn, cpuTurn;
        setCpu(1, 0, 32'h10, 0);
        for (int i = 0; i < 22; i++) begin
            setDma(beat < 12, 1, 1, 32'h40 + beat, 32'hA0000000 + beat);
            dmaTurn = (i >= 4 && i <= 11) || (i >= 16 && i <= 19);
            cpuTurn = !dmaTurn && i != 20;
            if (dmaTurn)
                sbq.push_back(mk(0, 1, 1, 1, 0, 32'h40 + beat, 0, 0, 0));
            else if (cpuTurn)
                sbq.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 0, 32'hDEADBEEF));
            else
                sbq.push_back(mk(0, 0, 1, 0, 0, 32'h0, 0, 0, 0));
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs !== e.vec) begin bad++; $display("FAIL lock_burst cyc%0d got=%h want=%h", i, obs, e.vec); end
            if (e.chk) begin
                total++;
                if (cpu_rdata !== e.data) begin bad++; $display("FAIL lock_burst_data cyc%0d got=%h want=%h", i, cpu_rdata, e.data); end
            end
            if (i >= 4 && i <= 12 && cpu_stall) stalls++;
            @(posedge clk); #1;
            if (dmaTurn) beat++;
        end
        total++;
        if (stalls != 8) begin bad++; $display("FAIL lock_burst_stall_cycles got=%0d want=8", stalls); end
        for (int k = 0; k < 12; k++) begin
            total++;
            if (tbMem[8'h40 + k] !== 32'hA0000000 + k) begin
                bad++; $display("FAIL lock_burst_mem beat%0d got=%h want=%h", k, tbMem[8'h40 + k], 32'hA0000000 + k);
            end
        end
        setCpu(0, 0, 0, 0);
        setDma(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_burst();
        setDma(1, 1, 1, 32'h80, 32'h11111111);
        sbq.push_back(mk(0, 1, 0, 1, 0, 32'h80, 0, 0, 0));
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if (obs !== e.vec) begin bad++; $display("FAIL midreset_beat1 got=%h want=%h", obs, e.vec); end
        @(posedge clk); #1;
        setDma(1, 1, 1, 32'h81, 32'h22222222);
        setCpu(1, 0, 32'h10, 0);
        sbq.push_back(mk(0, 1, 1, 1, 0, 32'h81, 0, 0, 0));
        sbq.push_back(mk(0, 0, 1, 0, 0, 32'h0, 0, 0, 0));
        #1;
        e = sbq.pop_front();
        total++;
        if (obs !== e.vec) begin bad++; $display("FAIL midreset_beat2 got=%h want=%h", obs, e.vec); end
        #1 reset = 1;
        #1;
        e = sbq.pop_front();
        total++;
        if (obs !== e.vec) begin bad++; $display("FAIL midreset_async got=%h want=%h", obs, e.vec); end
        total++;
        if (owner !== 2'b00) begin bad++; $display("FAIL midreset_owner got=%b want=00", owner); end
        @(posedge clk); #1;
        total++;
        if (tbMem[8'h81] !== 32'h0) begin bad++; $display("FAIL midreset_no_commit got=%h want=0", tbMem[8'h81]); end
        reset = 0;
        setDma(1, 0, 0, 32'h14, 0);
        sbq.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 0, 32'hDEADBEEF));
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        if (obs !== e.vec) begin bad++; $display("FAIL midreset_first_contest got=%h want=%h", obs, e.vec); end
        total++;
        if (cpu_rdata !== e.data) begin bad++; $display("FAIL midreset_data got=%h want=%h", cpu_rdata, e.data); end
        @(posedge clk); #1;
        setCpu(0, 0, 0, 0);
        setDma(0, 0, 0, 0, 0);
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            sbq.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
            @(negedge clk);
            e = sbq.pop_front();
            total++;
            if (obs !== e.vec) begin bad++; $display("FAIL idle cyc%0d got=%h want=%h", i, obs, e.vec); end
            total++;
            if (owner !== 2'b01) begin bad++; $display("FAIL idle_owner cyc%0d got=%b want=01", i, owner); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbMem[i] = 32'h0;
        tbMem[8'h14] = 32'h0BADF00D;
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_starvation();
        test_lock_burst();
        test_reset_mid_burst();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between the processor load/store path and a DMA/IO requester. Grants at most one requester per cycle, with fixed CPU priority, starvation-bounded DMA promotion and bounded DMA burst locking. Sits between the processor's DataMemory control signals (MemRead/MemWrite/ALU address/ReadData2) and the memory instance, and drives a stall to the processor's PC update.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA wins a contested cycle (1..15)
- LOCK_MAX, 8, maximum granted beats in one locked DMA burst (1..15)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_req  in  1  CPU access request (MemRead | MemWrite)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdata  out  DATA_WIDTH  read data; valid when cpu_ack=1 and cpu_we=0
- cpu_ack  out  1  CPU granted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes PC/pipeline
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  DMA request, as CPU
- dma_lock  in  1  request to hold grant across following beats
- dma_rdata  out  DATA_WIDTH  read data; valid when dma_ack=1 and dma_we=0
- dma_ack  out  1  DMA granted this cycle
- mem_addr, mem_wdata  out  ADDR_WIDTH/DATA_WIDTH  to memory; 0 when no grant
- mem_we, mem_re  out  1  granted & we / granted & ~we
- mem_rdata  in  DATA_WIDTH  combinational memory read data
- owner  out  2  registered last grant: 00 none, 01 CPU, 10 DMA

## Operation
- State: FREE or LOCKED; wait_cnt (4 b, saturates at STARVE_LIMIT); lock_cnt (4 b); owner.
- FREE grant: only one requester → it; both → DMA if wait_cnt == STARVE_LIMIT, else CPU; none → no grant.
- LOCKED grant: DMA if dma_req; CPU never granted (cpu_stall=cpu_req).
- wait_cnt: dma_req & ~dma_ack → +1 (saturating); dma_ack or ~dma_req → 0.
- FREE→LOCKED: dma_ack & dma_lock; lock_cnt ← 1.
- LOCKED, dma_ack & dma_lock & lock_cnt < LOCK_MAX → stay, lock_cnt+1.
- LOCKED→FREE: ~dma_req, or ~dma_lock on a granted beat, or granted beat with lock_cnt == LOCK_MAX. lock_cnt ← 0; wait_cnt ← 0.
- Forced release (LOCK_MAX reached): first FREE cycle after is CPU-preferred regardless of wait_cnt (wait_cnt cleared guarantees this).
- cpu_rdata = dma_rdata = mem_rdata unconditionally; only ack qualifies validity.
- Write commits at the clk edge ending the granted cycle.

## Timing
- Grant, acks, stall, mem_* are combinational from requests and current state: zero-cycle latency.
- Each access occupies exactly one cycle; requester holds req/addr/wdata stable until ack.
- Reset (asserted): FREE, wait_cnt=0, lock_cnt=0, owner=00, cpu_ack=dma_ack=mem_we=mem_re=0, mem_addr=mem_wdata=0, cpu_stall=cpu_req.
- Reset mid-burst: lock and counts cleared immediately; no write commits while reset high.
- Worst-case CPU stall: LOCK_MAX cycles in a burst; uncontended worst-case DMA wait: STARVE_LIMIT cycles.
- owner updates one edge after the grant; holds value on idle cycles (00 only after reset).

## Test plan
- Reset then cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, dma idle → cpu_ack=1, mem_we=1, mem_addr=0x10, stall=0; next read of 0x10 returns 0xDEADBEEF, owner=01.
- Both requesting reads continuously, STARVE_LIMIT=4 → CPU acked cycles 0–3, DMA acked cycle 4, CPU cycle 5, pattern repeats; cpu_stall=1 only on cycle 4.
- DMA dma_lock=1 writes 12 beats, CPU requesting, LOCK_MAX=8 → DMA acked 8 consecutive cycles, CPU acked next cycle, DMA resumes; cpu_stall high exactly 8 cycles.
- Locked burst with dma_req dropped after 3 beats → state FREE next cycle; CPU acked immediately if requesting.
- Reset asserted during locked burst beat 2 → all acks/mem_we low asynchronously; after release, CPU wins first contested cycle, wait_cnt=0.
- No requests for 5 cycles → mem_re=mem_we=0, mem_addr=0, owner keeps last value.
